// File: rtl/iob_fifo_burst_rd_pkg.sv
// Shared types and helpers for the iob_fifo_burst_rd read-side burst controller.
package iob_fifo_burst_rd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } burst_state_t;

    function automatic int blen_width(input int burst_max);
        return $clog2(burst_max) + 1;
    endfunction

    // A requested length of 0 means one word; anything above burst_max saturates.
    function automatic int clamp_len(input int len, input int burst_max);
        if (len < 1) return 1;
        if (len > burst_max) return burst_max;
        return len;
    endfunction

endpackage

// File: rtl/iob_skid_buf2.sv
// Two-entry valid/ready output buffer carrying a last-beat tag per entry.
// occupancy reports the entries still held once this cycle's dequeue is taken.
module iob_skid_buf2 #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic [1:0]        occupancy
);

    logic [DATA_W-1:0] data_q [2];
    logic [1:0]        last_q;
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic              deq;

    assign out_valid = (count_q != 2'd0);
    assign out_data  = data_q[rd_ptr_q];
    assign out_last  = out_valid & last_q[rd_ptr_q];
    assign deq       = out_valid & out_ready;
    assign occupancy = count_q - {1'b0, deq};

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            last_q    <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else if (clr) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            last_q    <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (in_valid) begin
                data_q[wr_ptr_q] <= in_data;
                last_q[wr_ptr_q] <= in_last;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (deq) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, in_valid} - {1'b0, deq};
        end
    end

endmodule

// File: rtl/iob_fifo_burst_rd.sv
// Read-side burst controller for one sync FIFO: decides when to drain, negotiates a
// burst via req/ack, pops the granted count and streams it out. Option: IOB_FIFO_BURST_RD_STATS_EN.
//   state | meaning
//   IDLE  | watching level / partial-burst timer
//   REQ   | burst_req high, burst_len frozen until burst_ack
//   XFER  | popping granted words and streaming them out
module iob_fifo_burst_rd
    import iob_fifo_burst_rd_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int BURST_MAX = 8,
    parameter int TIMEOUT_W = 8,
    parameter int BLEN_W    = blen_width(BURST_MAX)
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 rst,
    input  logic                 cfg_en,
    input  logic [BLEN_W-1:0]    cfg_burst_len,
    input  logic [TIMEOUT_W-1:0] cfg_timeout,
    input  logic [ADDR_W:0]      fifo_level,
    input  logic                 fifo_r_empty,
    output logic                 fifo_r_en,
    input  logic [DATA_W-1:0]    fifo_r_data,
    output logic                 burst_req,
    output logic [BLEN_W-1:0]    burst_len,
    input  logic                 burst_ack,
    output logic                 m_valid,
    output logic [DATA_W-1:0]    m_data,
    output logic                 m_last,
    input  logic                 m_ready,
    output logic                 busy
`ifdef IOB_FIFO_BURST_RD_STATS_EN
    ,
    output logic [15:0]          stat_bursts,
    output logic [15:0]          stat_partial
`endif
);

    localparam int LVL_W = ADDR_W + 1;
    localparam logic [TIMEOUT_W-1:0] TCNT_MAX = {TIMEOUT_W{1'b1}};

    burst_state_t          state_q, state_d;
    logic [TIMEOUT_W-1:0]  tcnt_q;
    logic [BLEN_W-1:0]     len_q;
    logic [BLEN_W-1:0]     pops_left_q;
    logic [BLEN_W-1:0]     beats_left_q;
    logic                  inflight_q;
    logic                  inflight_last_q;

    logic [BLEN_W-1:0]     eff_len;
    logic [LVL_W-1:0]      eff_len_lvl;
    logic                  full_trig;
    logic                  part_zone;
    logic                  part_trig;
    logic                  start_burst;
    logic                  beat_fire;
    logic                  last_handshake;
    logic [1:0]            buf_occ;
    logic                  pop_room;

    assign eff_len     = BLEN_W'(clamp_len(int'(cfg_burst_len), BURST_MAX));
    assign eff_len_lvl = LVL_W'(eff_len);

    assign full_trig = (fifo_level >= eff_len_lvl);
    assign part_zone = (fifo_level != '0) && !full_trig;
    assign part_trig = part_zone && (cfg_timeout != '0) && (tcnt_q == cfg_timeout);

    assign beat_fire      = m_valid & m_ready;
    assign last_handshake = (state_q == XFER) && beat_fire && (beats_left_q == BLEN_W'(1));

    // Buffer occupancy already accounts for this cycle's dequeue, so streaming sustains one beat per cycle.
    assign pop_room  = (({1'b0, buf_occ} + {2'b00, inflight_q}) < 3'd2);
    assign fifo_r_en = (state_q == XFER) && (pops_left_q != '0) && !fifo_r_empty && pop_room && !rst;

    assign burst_len = len_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        burst_req   = 1'b0;
        start_burst = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_en && (full_trig || part_trig)) begin
                    state_d     = REQ;
                    start_burst = 1'b1;
                end
            end
            REQ: begin
                burst_req = 1'b1;
                if (burst_ack) state_d = XFER;
            end
            XFER: begin
                if (last_handshake) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q         <= IDLE;
            tcnt_q          <= '0;
            len_q           <= '0;
            pops_left_q     <= '0;
            beats_left_q    <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else if (rst) begin
            state_q         <= IDLE;
            tcnt_q          <= '0;
            len_q           <= '0;
            pops_left_q     <= '0;
            beats_left_q    <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q <= state_d;

            if ((state_q != IDLE) || (state_d != IDLE) || !part_zone) begin
                tcnt_q <= '0;
            end else if (tcnt_q != TCNT_MAX) begin
                tcnt_q <= tcnt_q + TIMEOUT_W'(1);
            end

            if (start_burst) begin
                len_q <= full_trig ? eff_len : BLEN_W'(fifo_level);
            end

            if ((state_q == REQ) && burst_ack) begin
                pops_left_q  <= len_q;
                beats_left_q <= len_q;
            end else begin
                if (fifo_r_en) pops_left_q <= pops_left_q - BLEN_W'(1);
                if (beat_fire) beats_left_q <= beats_left_q - BLEN_W'(1);
            end

            inflight_q      <= fifo_r_en;
            inflight_last_q <= fifo_r_en && (pops_left_q == BLEN_W'(1));
        end
    end

    iob_skid_buf2 #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .arst_n    (arst_n),
        .clr       (rst),
        .in_valid  (inflight_q),
        .in_data   (fifo_r_data),
        .in_last   (inflight_last_q),
        .out_valid (m_valid),
        .out_data  (m_data),
        .out_last  (m_last),
        .out_ready (m_ready),
        .occupancy (buf_occ)
    );

`ifdef IOB_FIFO_BURST_RD_STATS_EN
    logic [15:0] stat_bursts_q;
    logic [15:0] stat_partial_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stat_bursts_q  <= '0;
            stat_partial_q <= '0;
        end else if (rst) begin
            stat_bursts_q  <= '0;
            stat_partial_q <= '0;
        end else begin
            if (last_handshake && (stat_bursts_q != 16'hFFFF)) begin
                stat_bursts_q <= stat_bursts_q + 16'd1;
            end
            if (start_burst && !full_trig && (stat_partial_q != 16'hFFFF)) begin
                stat_partial_q <= stat_partial_q + 16'd1;
            end
        end
    end

    assign stat_bursts  = stat_bursts_q;
    assign stat_partial = stat_partial_q;
`endif

endmodule

// File: tb/tb_iob_fifo_burst_rd.sv
// Self-checking bench for iob_fifo_burst_rd: behavioural FIFO plus an ordered word
// queue as reference; randomized data, ready patterns, ack delays and FIFO starvation.
module tb_iob_fifo_burst_rd;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        rst;
    logic        cfg_en;
    logic [3:0]  cfg_burst_len;
    logic [7:0]  cfg_timeout;
    logic [4:0]  fifo_level = '0;
    logic        fifo_empty_q = 1'b1;
    logic        force_empty;
    logic        fifo_r_empty;
    logic        fifo_r_en;
    logic [31:0] fifo_r_data = '0;
    logic        burst_req;
    logic [3:0]  burst_len;
    logic        burst_ack;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_ready;
    logic        busy;
`ifdef IOB_FIFO_BURST_RD_STATS_EN
    logic [15:0] stat_bursts;
    logic [15:0] stat_partial;
`endif

    logic        wr_en;
    logic [31:0] wr_data;

    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];
    int          pops_total = 0;
    int          beats_total = 0;
    int          checks = 0;
    int          errors = 0;
    int          exp_bursts = 0;
    int          exp_partial = 0;

    always #5 clk = ~clk;

    assign fifo_r_empty = fifo_empty_q | force_empty;

    iob_fifo_burst_rd dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .rst           (rst),
        .cfg_en        (cfg_en),
        .cfg_burst_len (cfg_burst_len),
        .cfg_timeout   (cfg_timeout),
        .fifo_level    (fifo_level),
        .fifo_r_empty  (fifo_r_empty),
        .fifo_r_en     (fifo_r_en),
        .fifo_r_data   (fifo_r_data),
        .burst_req     (burst_req),
        .burst_len     (burst_len),
        .burst_ack     (burst_ack),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_last        (m_last),
        .m_ready       (m_ready),
        .busy          (busy)
`ifdef IOB_FIFO_BURST_RD_STATS_EN
        ,
        .stat_bursts   (stat_bursts),
        .stat_partial  (stat_partial)
`endif
    );

    // Behavioural sync FIFO: read data appears one cycle after the pop.
    always @(posedge clk) begin
        if (fifo_r_en) begin
            if (fifo_q.size() > 0) fifo_r_data <= fifo_q.pop_front();
            pops_total++;
        end
        if (wr_en) fifo_q.push_back(wr_data);
        fifo_level   <= 5'(fifo_q.size());
        fifo_empty_q <= (fifo_q.size() == 0);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_words(input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = $urandom;
            exp_q.push_back(wr_data);
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    // Waits for a request, acks after ack_dly cycles, then consumes exp_len beats.
    // rdy_mode: 0 always ready, 1 pattern 1,0,0,..., 2 random. starve randomly hides FIFO data.
    task automatic do_burst(input int exp_len, input int ack_dly, input int rdy_mode, input bit starve);
        int          w;
        int          it;
        int          pops0;
        int          beats;
        logic        stall_prev;
        logic [31:0] hold_data;
        logic        hold_last;
        logic [31:0] exp_word;
        w = 0;
        while (!burst_req && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("req_seen", burst_req, 1);
        check("burst_len", burst_len, exp_len);
        for (int i = 0; i < ack_dly; i++) begin
            check("no_pop_before_ack", fifo_r_en, 0);
            @(negedge clk);
            check("req_held", burst_req, 1);
            check("len_held", burst_len, exp_len);
        end
        burst_ack = 1'b1;
        @(negedge clk);
        burst_ack  = 1'b0;
        pops0      = pops_total;
        beats      = 0;
        it         = 0;
        stall_prev = 1'b0;
        hold_data  = '0;
        hold_last  = 1'b0;
        while (beats < exp_len && it < 400) begin
            if (stall_prev) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, hold_data);
                check("hold_last", m_last, hold_last);
            end
            check("outstanding_le2", (pops_total - beats_total) <= 2, 1);
            force_empty = starve ? 1'($urandom_range(0, 1)) : 1'b0;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (it % 3 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (m_valid && m_ready) begin
                exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                check("beat_data", m_data, exp_word);
                check("beat_last", m_last, beats == exp_len - 1);
                beats++;
                beats_total++;
            end else if (m_valid && m_last) begin
                check("early_last", beats == exp_len - 1, 1);
            end
            stall_prev = m_valid && !m_ready;
            hold_data  = m_data;
            hold_last  = m_last;
            @(negedge clk);
            it++;
        end
        m_ready     = 1'b0;
        force_empty = 1'b0;
        check("beats_done", beats, exp_len);
        if (rdy_mode == 0 && !starve) check("throughput_cycles", it, exp_len + 2);
        check("pop_count", pops_total - pops0, exp_len);
        check("busy_fall", busy, 0);
        check("valid_fall", m_valid, 0);
        exp_bursts++;
    endtask

    // Partial burst: the timer starts once the first word lands and REQ registers on the
    // edge after it reaches the timeout, i.e. timeout+2 cycles after the first write is driven.
    task automatic partial_burst(input int n, input int to);
        int k;
        cfg_burst_len = 4'd8;
        cfg_timeout   = 8'(to);
        write_words(n);
        k = n;
        while (!burst_req && k < 300) begin
            check("no_early_partial", k < to + 2, 1);
            @(negedge clk);
            k++;
        end
        check("partial_req_time", k, to + 2);
        do_burst(n, 0, int'($urandom_range(0, 2)), 1'b0);
        exp_partial++;
    endtask

    initial begin
        int w;
        int lvl;
        int discard;
        int len;
        int nb;
        arst_n = 1'b0; rst = 1'b0; cfg_en = 1'b0; cfg_burst_len = 4'd4; cfg_timeout = 8'd0;
        force_empty = 1'b0; burst_ack = 1'b0; m_ready = 1'b0; wr_en = 1'b0; wr_data = '0;
        repeat (3) @(negedge clk);
        check("rst_req", burst_req, 0);
        check("rst_len", burst_len, 0);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_last", m_last, 0);
        check("rst_busy", busy, 0);
        check("rst_pop", fifo_r_en, 0);
        arst_n = 1'b1;
        @(negedge clk);

        // Full burst, ack one cycle later, always ready.
        cfg_en = 1'b1; cfg_burst_len = 4'd4; cfg_timeout = 8'd0;
        write_words(4);
        do_burst(4, 1, 0, 1'b0);

        // Timeout-triggered partial burst.
        partial_burst(3, 5);

        // Backpressure pattern.
        cfg_burst_len = 4'd4; cfg_timeout = 8'd0;
        write_words(4);
        do_burst(4, 1, 1, 1'b0);

        // Delayed ack while the FIFO holds 12; later bursts with starvation.
        write_words(12);
        do_burst(4, 10, 2, 1'b0);
        do_burst(4, int'($urandom_range(0, 3)), 2, 1'b1);
        do_burst(4, 0, 0, 1'b0);

        // cfg_en low: no request.
        cfg_en = 1'b0;
        write_words(4);
        repeat (10) @(negedge clk);
        check("no_req_disabled", burst_req, 0);
        check("idle_disabled", busy, 0);
        cfg_en = 1'b1;
        do_burst(4, 1, 0, 1'b0);

        // Timeout 0 disables partial bursts.
        write_words(2);
        repeat (20) @(negedge clk);
        check("no_partial_to0", burst_req, 0);
        write_words(2);
        do_burst(4, 0, 2, 1'b0);

        // Length boundaries: 0 acts as 1, above BURST_MAX saturates; cfg change during REQ ignored.
        cfg_burst_len = 4'd0;
        write_words(1);
        do_burst(1, 0, 0, 1'b0);
        cfg_burst_len = 4'd15;
        write_words(10);
        cfg_burst_len = 4'd2;
        do_burst(8, 2, 2, 1'b0);
        do_burst(2, 0, 0, 1'b0);

        // Soft clear during beat 2 of 4.
        cfg_burst_len = 4'd4;
        write_words(8);
        w = 0;
        while (!burst_req && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("rst_case_req", burst_req, 1);
        burst_ack = 1'b1;
        @(negedge clk);
        burst_ack = 1'b0;
        m_ready   = 1'b1;
        w = 0;
        while (!m_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("rst_case_valid1", m_valid, 1);
        check("rst_case_beat1", m_data, exp_q[0]);
        void'(exp_q.pop_front());
        beats_total++;
        @(negedge clk);
        check("rst_case_valid2", m_valid, 1);
        rst = 1'b1; m_ready = 1'b0;
        @(negedge clk);
        check("clr_valid", m_valid, 0);
        check("clr_req", burst_req, 0);
        check("clr_busy", busy, 0);
        check("clr_last", m_last, 0);
        check("clr_data", m_data, 0);
        check("clr_pop", fifo_r_en, 0);
        rst = 1'b0;
        exp_bursts  = 0;
        exp_partial = 0;
        discard = pops_total - beats_total;
        for (int i = 0; i < discard; i++) if (exp_q.size() > 0) void'(exp_q.pop_front());
        beats_total = pops_total;
        lvl = fifo_q.size();
        check("clr_level_ge4", lvl >= 4, 1);
        do_burst(4, 0, 0, 1'b0);
        if (lvl > 4) begin
            cfg_burst_len = 4'(lvl - 4);
            do_burst(lvl - 4, 0, 2, 1'b0);
        end

        // Randomized full bursts.
        for (int r = 0; r < 8; r++) begin
            len = int'($urandom_range(1, 8));
            nb  = int'($urandom_range(1, 2));
            cfg_burst_len = 4'(len);
            cfg_timeout   = 8'd0;
            write_words(len * nb);
            for (int b = 0; b < nb; b++) begin
                do_burst(len, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
            end
        end

        partial_burst(2, 4);
        check("fifo_drained", fifo_q.size(), 0);

`ifdef IOB_FIFO_BURST_RD_STATS_EN
        check("stat_bursts", stat_bursts, exp_bursts);
        check("stat_partial", stat_partial, exp_partial);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed still running, expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/iob_fifo_burst_rd.md
Name: iob_fifo_burst_rd

Overview:
- Read-side controller for one iob_fifo_sync instance (symmetric widths).
- Watches FIFO level, decides when to drain, negotiates a burst with a downstream consumer (req/ack), then pops exactly the granted count.
- Streams the popped words out on a valid/ready interface with last-beat marking.
- Sits between the FIFO read port and a DMA/bus-master engine.

Parameters:
- DATA_W, 32, FIFO word width.
- ADDR_W, 4, FIFO address width; level is ADDR_W+1 bits.
- BURST_MAX, 8, maximum words per burst; power of two, at most 2**ADDR_W.
- TIMEOUT_W, 8, width of the partial-burst timeout counter.
- BLEN_W, $clog2(BURST_MAX)+1, derived burst-length width.

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous reset, active-low
- rst  in  1  synchronous soft clear, active-high
- cfg_en  in  1  enable new bursts
- cfg_burst_len  in  BLEN_W  burst threshold and length
- cfg_timeout  in  TIMEOUT_W  idle cycles before a partial burst; 0 disables partial bursts
- fifo_level  in  ADDR_W+1  FIFO level
- fifo_r_empty  in  1  FIFO empty
- fifo_r_en  out  1  FIFO pop
- fifo_r_data  in  DATA_W  FIFO read data; valid one cycle after fifo_r_en
- burst_req  out  1  burst request
- burst_len  out  BLEN_W  words in the requested burst
- burst_ack  in  1  request accepted
- m_valid  out  1  output data valid
- m_data  out  DATA_W  output data
- m_last  out  1  final beat of the burst
- m_ready  in  1  consumer ready
- busy  out  1  state is not IDLE

Behaviour:
- Reset (arst_n low, or rst high at a clock edge): state IDLE; all outputs 0; timeout counter 0; buffer empty.
- Effective length L = clamp(cfg_burst_len, 1, BURST_MAX); a value of 0 is treated as 1.
- States:
  - IDLE.
    - Full trigger: cfg_en and fifo_level >= L → REQ, latching burst_len = L.
    - Partial trigger: cfg_en and 0 < fifo_level < L and tcnt == cfg_timeout with cfg_timeout != 0 → REQ, latching burst_len = fifo_level.
    - Timeout counter tcnt: increments while in IDLE with 0 < fifo_level < L; cleared when fifo_level == 0, when fifo_level >= L, or on leaving IDLE; saturates at its maximum.
  - REQ.
    - burst_req = 1 and burst_len is held stable until burst_ack.
    - Transition to XFER on the cycle burst_ack is sampled high.
    - burst_ack while in IDLE or XFER is ignored.
  - XFER.
    - pops_left counts down from burst_len; beats_left counts down on each m_valid & m_ready.
    - fifo_r_en = (pops_left != 0) & ~fifo_r_empty & (occupancy + inflight < 2).
    - Data is captured into a 2-entry output buffer one cycle after the pop.
    - m_last = 1 exactly when beats_left == 1 and m_valid.
    - Return to IDLE after the last-beat handshake; the earliest new request is the next cycle.
- Throughput: one beat per cycle with m_ready held high; first m_valid appears 2 cycles after entering XFER.
- Backpressure: with m_ready low, m_valid/m_data/m_last hold stable; at most 2 words are popped ahead of the consumer.
- fifo_r_empty mid-burst (level read stale): popping stalls and resumes when the FIFO is non-empty; no word is dropped or duplicated.
- cfg_en deasserted mid-burst: the current burst completes; no new request is made.
- cfg changes during REQ/XFER have no effect until the next IDLE decision.
- rst mid-burst: immediate return to IDLE; buffer and in-flight data are discarded; outstanding burst_req is withdrawn.

Optional Feature:
- Macro: IOB_FIFO_BURST_RD_STATS_EN.
- Defined:
  - Adds output stat_bursts[15:0], counting completed bursts.
  - Adds output stat_partial[15:0], counting timeout-triggered bursts.
  - Both counters saturate at 16'hFFFF and clear on any reset.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package iob_fifo_burst_rd_pkg:
  - state encoding IDLE=2'd0, REQ=2'd1, XFER=2'd2;
  - BLEN_W derivation;
  - clamp function for L.
- Sub-module iob_skid_buf2: 2-entry valid/ready output buffer with occupancy output; it also holds the m_last tag per entry.

Test Plan:
- L=4, write 4 words (A,B,C,D), ack 1 cycle later, m_ready=1 → burst_len=4; beats A,B,C,D in 4 consecutive cycles; m_last only on D; busy falls after D.
- L=8, cfg_timeout=5, write 3 words then stop → burst_req with burst_len=3 after tcnt reaches 5; 3 beats, last on beat 3.
- L=4, m_ready toggling 1,0,0,1,… → data stable while stalled; exactly 4 pops; no more than 2 words outstanding; order preserved.
- burst_ack delayed 10 cycles while the FIFO fills to 12 → burst_len stays 4; fifo_r_en stays 0 until ack.
- rst pulse during beat 2 of 4 → outputs 0 the next cycle, state IDLE; with level >= 4 a fresh request is issued.
- With IOB_FIFO_BURST_RD_STATS_EN: 3 full bursts + 1 timeout burst → stat_bursts=4, stat_partial=1.
